// File: rtl/rx_buff_bank_ctrl.sv
// rx_buff_bank_ctrl
// Steers an always-accepted word stream into the two halves (banks) of an
// external rx_buff RAM that is written on every clock. Frames are packed into
// the currently FILLING bank; when a new frame no longer fits, that bank is
// closed and handed to the reader, and filling moves to the other bank.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   wr_valid, wr_data, wr_last   incoming word stream (wr_last = end of frame)
//   buff_a, buff_d               registered rx_buff write address / data
//   bank_ready[1:0]              bank b holds valid data for the reader
//   bank0_len, bank1_len         valid word count per bank
//   bank_done[1:0]               one-cycle release pulse from the reader
//   drop_cnt                     saturating count of dropped/truncated frames
//   dbg_bank_st                  {bank1 state, bank0 state} for observation
//
// Optional feature: define RX_BUFF_TIMEOUT_EN to close a partially filled
// bank after TIMEOUT idle cycles between frames.
//
// Stream handshake: there is no back-pressure. Every cycle with wr_valid
// high transfers one word; words that cannot be stored are discarded and the
// affected frame is counted once in drop_cnt.
module rx_buff_bank_ctrl #(
  parameter int AW            = 10,
  parameter int DW            = 64,
  parameter int MAX_FRM_WORDS = 200,
  parameter int TIMEOUT       = 1024
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          wr_valid,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_last,
  output logic [AW-1:0] buff_a,
  output logic [DW-1:0] buff_d,
  output logic [1:0]    bank_ready,
  output logic [AW-2:0] bank0_len,
  output logic [AW-2:0] bank1_len,
  input  logic [1:0]    bank_done,
  output logic [31:0]   drop_cnt,
  output logic [3:0]    dbg_bank_st
);

  localparam int LW = AW - 1;
  // Top word of each bank is a scratch slot used as the parking address.
  localparam logic [LW-1:0] CAP    = {LW{1'b1}};
  localparam logic [LW-1:0] MAXW   = LW'(MAX_FRM_WORDS);
  localparam logic [LW-1:0] LEN_1  = LW'(1);
  localparam logic [31:0]   DROP_1 = 32'd1;

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_CLOSING, B_READY} bank_st_e;

  bank_st_e      st_q [2], st_d [2];
  logic [LW-1:0] len_q [2], len_d [2];
  logic          close_ph_q [2], close_ph_d [2]; // high in second CLOSING cycle
  logic          last_filled_q, last_filled_d;
  logic          in_frame_q, in_frame_d;         // next word is not a sof
  logic          frm_drop_q, frm_drop_d;         // current frame already counted as dropped
  logic [LW-1:0] frm_cnt_q, frm_cnt_d;           // words stored for current frame
  logic [31:0]   drop_q, drop_d;
  logic [AW-1:0] buff_a_q, buff_a_d;
  logic [DW-1:0] buff_d_q, buff_d_d;

  logic fill_vld, fill_b, room_ok, drop_inc, wr_en, wr_bank, alt_b;

`ifdef RX_BUFF_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT);
  localparam logic [IW-1:0] IDLE_1   = IW'(1);
  logic [IW-1:0] idle_q, idle_d;
`endif

  assign fill_vld = (st_q[0] == B_FILLING) || (st_q[1] == B_FILLING);
  assign fill_b   = (st_q[1] == B_FILLING);
  assign room_ok  = (CAP - len_q[fill_b]) >= MAXW;

  always_comb begin
    st_d          = st_q;
    len_d         = len_q;
    close_ph_d    = close_ph_q;
    last_filled_d = last_filled_q;
    in_frame_d    = in_frame_q;
    frm_drop_d    = frm_drop_q;
    frm_cnt_d     = frm_cnt_q;
    buff_a_d      = buff_a_q;
    buff_d_d      = buff_d_q;
    drop_inc      = 1'b0;
    wr_en         = 1'b0;
    wr_bank       = 1'b0;
    alt_b         = 1'b0;
`ifdef RX_BUFF_TIMEOUT_EN
    idle_d        = idle_q;
`endif

    // CLOSING spans two cycles so the last registered write lands first.
    // Releases act on the pre-release state; sof logic below never touches
    // a READY bank, so the two cannot collide.
    for (int b = 0; b < 2; b++) begin
      if (st_q[b] == B_CLOSING) begin
        close_ph_d[b] = ~close_ph_q[b];
        if (close_ph_q[b]) st_d[b] = B_READY;
      end else if (st_q[b] == B_READY && bank_done[b]) begin
        st_d[b]  = B_FREE;
        len_d[b] = '0;
      end
    end

    if (wr_valid) begin
      in_frame_d = ~wr_last;
`ifdef RX_BUFF_TIMEOUT_EN
      idle_d = '0;
`endif
      if (!in_frame_q) begin
        frm_cnt_d  = '0;
        frm_drop_d = 1'b0;
        if (fill_vld && room_ok) begin
          wr_en   = 1'b1;
          wr_bank = fill_b;
        end else begin
          if (fill_vld) begin
            st_d[fill_b]       = B_CLOSING;
            close_ph_d[fill_b] = 1'b0;
          end
          // Strict alternation: the candidate is always the bank not last filled.
          alt_b = fill_vld ? ~fill_b : ~last_filled_q;
          if (st_q[alt_b] == B_FREE) begin
            st_d[alt_b]   = B_FILLING;
            last_filled_d = alt_b;
            wr_en         = 1'b1;
            wr_bank       = alt_b;
          end else begin
            frm_drop_d = 1'b1;
            drop_inc   = 1'b1;
          end
        end
      end else if (!frm_drop_q) begin
        if (frm_cnt_q < MAXW) begin
          wr_en   = 1'b1;
          wr_bank = fill_b;
        end else begin
          frm_drop_d = 1'b1;
          drop_inc   = 1'b1;
        end
      end
    end else begin
`ifdef RX_BUFF_TIMEOUT_EN
      if (idle_q != IDLE_MAX) idle_d = idle_q + IDLE_1;
      if (fill_vld && len_q[fill_b] != '0 && !in_frame_q && idle_d == IDLE_MAX) begin
        st_d[fill_b]       = B_CLOSING;
        close_ph_d[fill_b] = 1'b0;
        idle_d             = '0;
      end
`endif
    end

    if (wr_en) begin
      buff_a_d         = {wr_bank, len_q[wr_bank]};
      buff_d_d         = wr_data;
      len_d[wr_bank]   = len_q[wr_bank] + LEN_1;
      frm_cnt_d        = frm_cnt_d + LEN_1;
    end else if (st_d[0] == B_FILLING) begin
      buff_a_d = {1'b0, len_d[0]};
    end else if (st_d[1] == B_FILLING) begin
      buff_a_d = {1'b1, len_d[1]};
    end else begin
      buff_a_d = {last_filled_d, CAP};
    end

    drop_d = (drop_inc && drop_q != '1) ? drop_q + DROP_1 : drop_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q[0]       <= B_FREE;
      st_q[1]       <= B_FREE;
      len_q[0]      <= '0;
      len_q[1]      <= '0;
      close_ph_q[0] <= 1'b0;
      close_ph_q[1] <= 1'b0;
      last_filled_q <= 1'b1;
      in_frame_q    <= 1'b0;
      frm_drop_q    <= 1'b0;
      frm_cnt_q     <= '0;
      drop_q        <= '0;
      buff_a_q      <= {1'b1, CAP};
      buff_d_q      <= '0;
`ifdef RX_BUFF_TIMEOUT_EN
      idle_q        <= '0;
`endif
    end else begin
      st_q          <= st_d;
      len_q         <= len_d;
      close_ph_q    <= close_ph_d;
      last_filled_q <= last_filled_d;
      in_frame_q    <= in_frame_d;
      frm_drop_q    <= frm_drop_d;
      frm_cnt_q     <= frm_cnt_d;
      drop_q        <= drop_d;
      buff_a_q      <= buff_a_d;
      buff_d_q      <= buff_d_d;
`ifdef RX_BUFF_TIMEOUT_EN
      idle_q        <= idle_d;
`endif
    end
  end

  assign buff_a      = buff_a_q;
  assign buff_d      = buff_d_q;
  assign bank_ready  = {st_q[1] == B_READY, st_q[0] == B_READY};
  assign bank0_len   = len_q[0];
  assign bank1_len   = len_q[1];
  assign drop_cnt    = drop_q;
  assign dbg_bank_st = {st_q[1], st_q[0]};

endmodule

// File: tb/tb_rx_buff_bank_ctrl.sv
module tb_rx_buff_bank_ctrl;
  localparam int AW   = 4;
  localparam int DW   = 16;
  localparam int MAXW = 3;
  localparam int TO   = 16;
  localparam int CAP  = 7;
  localparam int BSZ  = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic [AW-1:0] buff_a;
  logic [DW-1:0] buff_d;
  logic [1:0]    bank_ready;
  logic [AW-2:0] bank0_len;
  logic [AW-2:0] bank1_len;
  logic [1:0]    bank_done;
  logic [31:0]   drop_cnt;
  logic [3:0]    dbg_bank_st;

  rx_buff_bank_ctrl #(.AW(AW), .DW(DW), .MAX_FRM_WORDS(MAXW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last),
    .buff_a(buff_a), .buff_d(buff_d),
    .bank_ready(bank_ready), .bank0_len(bank0_len), .bank1_len(bank1_len),
    .bank_done(bank_done), .drop_cnt(drop_cnt), .dbg_bank_st(dbg_bank_st)
  );

  // The rx_buff RAM itself, written every cycle from the registered port.
  logic [DW-1:0] ram [BSZ*2];
  always @(posedge clk) ram[buff_a] <= buff_d;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: bank state 0 FREE, 1 FILLING, 2 CLOSING, 3 READY.
  int            m_st [2];
  int            m_cc [2];
  int            m_len [2];
  logic [DW-1:0] m_mem [2][BSZ];
  bit            m_ver [2];
  int            m_lf;
  bit            m_inf;
  bit            m_ok;
  int            m_fn;
  longint        m_drop;
  int            m_idle;
  int            e_a;
  logic [DW-1:0] e_d;
  bit            e_wr;

  function automatic void m_reset();
    for (int b = 0; b < 2; b++) begin
      m_st[b] = 0; m_cc[b] = 0; m_len[b] = 0; m_ver[b] = 0;
    end
    m_lf = 1; m_inf = 0; m_ok = 0; m_fn = 0; m_drop = 0; m_idle = 0;
    e_a = 2*BSZ - 1; e_d = '0; e_wr = 0;
  endfunction

  function automatic void m_step(input bit v, input logic [DW-1:0] d, input bit l,
                                 input logic [1:0] dn);
    int ns [2];
    int fill, tgt, alt, wb, f2;
    ns = m_st;
    fill = (m_st[0] == 1) ? 0 : (m_st[1] == 1) ? 1 : -1;
    for (int b = 0; b < 2; b++) begin
      if (m_st[b] == 2) begin
        m_cc[b]--;
        if (m_cc[b] == 0) ns[b] = 3;
      end else if (m_st[b] == 3 && dn[b]) begin
        ns[b] = 0; m_len[b] = 0; m_ver[b] = 0;
      end
    end
    e_wr = 0;
    wb = -1;
    if (v) begin
      m_idle = 0;
      if (!m_inf) begin
        tgt = -1;
        if (fill >= 0 && (CAP - m_len[fill]) >= MAXW) tgt = fill;
        else begin
          if (fill >= 0) begin
            ns[fill] = 2; m_cc[fill] = 2; alt = 1 - fill;
          end else alt = 1 - m_lf;
          if (m_st[alt] == 0) begin
            ns[alt] = 1; m_lf = alt; tgt = alt;
          end
        end
        if (tgt >= 0) begin
          wb = tgt; m_ok = 1; m_fn = 0;
        end else begin
          m_ok = 0; m_drop++;
        end
      end else if (m_ok) begin
        if (m_fn < MAXW) wb = fill;
        else begin
          m_ok = 0; m_drop++;
        end
      end
      if (wb >= 0) begin
        m_mem[wb][m_len[wb]] = d;
        e_a = wb*BSZ + m_len[wb];
        e_d = d;
        e_wr = 1;
        m_len[wb]++;
        m_fn++;
      end
      m_inf = !l;
    end else begin
`ifdef RX_BUFF_TIMEOUT_EN
      if (m_idle < TO) m_idle++;
      if (fill >= 0 && ns[fill] == 1 && m_len[fill] > 0 && !m_inf && m_idle >= TO) begin
        ns[fill] = 2; m_cc[fill] = 2; m_idle = 0;
      end
`endif
    end
    m_st = ns;
    if (m_drop > 64'hFFFF_FFFF) m_drop = 64'hFFFF_FFFF;
    if (!e_wr) begin
      f2 = (m_st[0] == 1) ? 0 : (m_st[1] == 1) ? 1 : -1;
      e_a = (f2 >= 0) ? f2*BSZ + m_len[f2] : m_lf*BSZ + CAP;
    end
  endfunction

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [1:0] er;
    er = {m_st[1] == 3, m_st[0] == 3};
    chk("bank_ready", 32'(bank_ready), 32'(er));
    chk("bank0_len", 32'(bank0_len), 32'(m_len[0]));
    chk("bank1_len", 32'(bank1_len), 32'(m_len[1]));
    chk("drop_cnt", drop_cnt, 32'(m_drop));
    chk("buff_a", 32'(buff_a), 32'(e_a));
    if (e_wr) chk("buff_d", 32'(buff_d), 32'(e_d));
    for (int b = 0; b < 2; b++) begin
      if (m_st[b] == 3 && !m_ver[b]) begin
        for (int i = 0; i < m_len[b]; i++)
          chk("ram_word", 32'(ram[b*BSZ + i]), 32'(m_mem[b][i]));
        m_ver[b] = 1;
      end
    end
  endtask

  // drivers
  task automatic tick(input bit v, input logic [DW-1:0] d, input bit l, input logic [1:0] dn);
    wr_valid = v; wr_data = d; wr_last = l; bank_done = dn;
    m_step(v, d, l, dn);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [1:0] rnd_done();
    return {$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0};
  endfunction

  task automatic send_frame(input int n, input bit rnd);
    for (int i = 0; i < n; i++)
      tick(1'b1, DW'($urandom), i == n - 1, rnd ? rnd_done() : 2'b00);
  endtask

  task automatic idle(input int n, input bit rnd);
    for (int i = 0; i < n; i++) tick(1'b0, '0, 1'b0, rnd ? rnd_done() : 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; bank_done = 2'b00;
    #1;
    m_reset();
    chk("rst_ready", 32'(bank_ready), 32'd0);
    chk("rst_len0", 32'(bank0_len), 32'd0);
    chk("rst_len1", 32'(bank1_len), 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    chk("rst_buff_a", 32'(buff_a), 32'd15);
    chk("rst_buff_d", 32'(buff_d), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin : main
    reset_n = 1'b0;
    wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0; bank_done = 2'b00;
    m_reset();
    do_reset();

    // first frame lands at 0,1,2 of bank 0
    send_frame(3, 0);
    idle(1, 0);
    chk("first_len0", 32'(bank0_len), 32'd3);
    chk("first_ready", 32'(bank_ready), 32'd0);

    // second frame fills bank 0 to 6; third frame sof closes it
    send_frame(3, 0);
    tick(1'b1, DW'($urandom), 1'b0, 2'b00);
    chk("third_at_8", 32'(buff_a), 32'd8);
    tick(1'b1, DW'($urandom), 1'b0, 2'b00);
    tick(1'b1, DW'($urandom), 1'b1, 2'b00);
    chk("close_ready", 32'(bank_ready), 32'd1);
    chk("close_len0", 32'(bank0_len), 32'd6);

    // bank 1 fills, next sof closes it with bank 0 still READY -> drop
    send_frame(3, 0);
    send_frame(2, 0);
    idle(2, 0);
    chk("both_ready", 32'(bank_ready), 32'd3);
    chk("both_drop", drop_cnt, 32'd1);
    chk("both_park", 32'(buff_a), 32'd15);

    // release of bank 0 in the same cycle as the sof needing it
    tick(1'b1, DW'($urandom), 1'b1, 2'b01);
    chk("rel_sof_drop", drop_cnt, 32'd2);
    tick(1'b1, DW'($urandom), 1'b1, 2'b00);
    chk("after_rel_idx0", 32'(buff_a), 32'd0);
    chk("after_rel_len0", 32'(bank0_len), 32'd1);

    // over-long frame is truncated to three words
    idle(1, 0);
    tick(1'b0, '0, 1'b0, 2'b10);
    send_frame(5, 0);
    chk("trunc_len0", 32'(bank0_len), 32'd4);
    chk("trunc_drop", drop_cnt, 32'd3);

    // idle close of a partial bank
    do_reset();
    send_frame(2, 0);
    idle(18, 0);
`ifdef RX_BUFF_TIMEOUT_EN
    chk("timeout_ready", 32'(bank_ready), 32'd1);
    chk("timeout_len0", 32'(bank0_len), 32'd2);
`else
    chk("no_timeout_ready", 32'(bank_ready), 32'd0);
`endif

    // reset in the middle of a frame, next word must be a sof
    send_frame(2, 0);
    tick(1'b1, DW'($urandom), 1'b0, 2'b00);
    do_reset();
    send_frame(2, 0);
    chk("post_rst_len0", 32'(bank0_len), 32'd2);

    // randomized traffic with a randomly releasing reader
    for (int f = 0; f < 80; f++) begin
      send_frame($urandom_range(1, 5), 1);
      if ($urandom_range(0, 7) == 0) idle(20, 1);
      else idle($urandom_range(0, 3), 1);
    end
    idle(4, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
